shift_count_reg: RTL and testbench

SHIFT_COUNT_REG -- requirements
Module: shift_count_reg

---
 rtl/shift_count_pkg.sv | 21 ++
 rtl/shift_count_reg_frame_counter.sv | 54 +++++
 rtl/shift_count_reg.sv | 87 ++++++++
 tb/tb_shift_count_reg.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_count_pkg.sv
// Shared definitions for the shift/count register.
//   mode_e    : operation select encoding for the mode input
//   cnt_width : number of bits needed to hold a shift count of 0..width
package shift_count_pkg;

    typedef enum logic [2:0] {
        MODE_HOLD   = 3'd0,
        MODE_SHL    = 3'd1,
        MODE_SHR    = 3'd2,
        MODE_LOAD   = 3'd3,
        MODE_CNT_UP = 3'd4,
        MODE_CNT_DN = 3'd5,
        MODE_ROTL   = 3'd6,
        MODE_ROTR   = 3'd7
    } mode_e;

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/shift_count_reg_frame_counter.sv
// Frame counter: counts shift events and pulses frame_done for one cycle
// after every WIDTH-th shift of a frame.
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   shift_evt  : an enabled shift/rotate happens on this edge
//   clr        : restart the frame (enabled LOAD)
//   frame_done : registered one-cycle pulse after the WIDTH-th shift
module frame_counter
    import shift_count_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic shift_evt,
    input  logic clr,
    output logic frame_done
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;

    always_comb begin
        cnt_d  = cnt_q;
        done_d = 1'b0;
        if (clr) begin
            cnt_d = '0;
        end else if (shift_evt) begin
            // The count never actually holds WIDTH: it wraps to 0 and
            // the completed frame is flagged instead.
            if (cnt_q == CW'(WIDTH - 1)) begin
                cnt_d  = '0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign frame_done = done_q;

endmodule

// File: rtl/shift_count_reg.sv
// Multi-mode register: hold, shift left/right, parallel load, count
// up/down and rotate left/right, with frame tracking of shifts.
//   clk, rst_n    : clock, asynchronous active-low reset
//   en            : operation enable (0 = hold everything)
//   mode          : operation select (see shift_count_pkg::mode_e)
//   sin_l / sin_r : serial input entering at MSB (SHR) / LSB (SHL)
//   d             : parallel load data
//   q             : register contents
//   sout_l/sout_r : q MSB / q LSB
//   tc            : terminal count for the selected count direction
//   frame_done    : one-cycle pulse after every WIDTH completed shifts
module shift_count_reg
    import shift_count_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             sin_l,
    input  logic             sin_r,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             tc,
    output logic             frame_done
);

    mode_e            mode_s;
    logic [WIDTH-1:0] q_q, q_d;
    logic             shift_evt;
    logic             clr;

    assign mode_s = mode_e'(mode);

    always_comb begin
        q_d = q_q;
        if (en) begin
            case (mode_s)
                MODE_HOLD:   q_d = q_q;
                MODE_SHL:    q_d = {q_q[WIDTH-2:0], sin_r};
                MODE_SHR:    q_d = {sin_l, q_q[WIDTH-1:1]};
                MODE_LOAD:   q_d = d;
                MODE_CNT_UP: q_d = q_q + WIDTH'(1);
                MODE_CNT_DN: q_d = q_q - WIDTH'(1);
                MODE_ROTL:   q_d = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
                MODE_ROTR:   q_d = {q_q[0], q_q[WIDTH-1:1]};
                default:     q_d = q_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= q_d;
        end
    end

    // All four shift/rotate modes advance the same frame count.
    assign shift_evt = en && ((mode_s == MODE_SHL)  || (mode_s == MODE_SHR) ||
                              (mode_s == MODE_ROTL) || (mode_s == MODE_ROTR));
    assign clr       = en && (mode_s == MODE_LOAD);

    frame_counter #(
        .WIDTH(WIDTH)
    ) u_frame_counter (
        .clk       (clk),
        .rst_n     (rst_n),
        .shift_evt (shift_evt),
        .clr       (clr),
        .frame_done(frame_done)
    );

    assign q      = q_q;
    assign sout_l = q_q[WIDTH-1];
    assign sout_r = q_q[0];

    // Terminal count looks at the selected direction only, not at en.
    assign tc = ((mode_s == MODE_CNT_UP) && (q_q == {WIDTH{1'b1}})) ||
                ((mode_s == MODE_CNT_DN) && (q_q == '0));

endmodule

// File: tb/tb_shift_count_reg.sv
module tb_shift_count_reg;

    localparam int         WIDTH = 8;
    localparam logic [7:0] RV    = 8'hA5;
    localparam int         MASK  = (1 << WIDTH) - 1;

    localparam logic [2:0] HOLD = 3'd0, SHL = 3'd1, SHR = 3'd2, LOAD = 3'd3,
                           CUP  = 3'd4, CDN = 3'd5, ROTL = 3'd6, ROTR = 3'd7;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic             sin_l, sin_r;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             sout_l, sout_r, tc, frame_done;

    shift_count_reg #(
        .WIDTH    (WIDTH),
        .RESET_VAL(RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .mode      (mode),
        .sin_l     (sin_l),
        .sin_r     (sin_r),
        .d         (d),
        .q         (q),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .tc        (tc),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] q;
        logic       fd;
        logic       tc;
    } exp_t;

    exp_t sbq[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model: register value as an integer, shifts done so far
    int mq;
    int mn;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic tc_of(input logic [2:0] m, input int v);
        return ((m == CUP) && (v == MASK)) || ((m == CDN) && (v == 0));
    endfunction

    task automatic step(input logic e, input logic [2:0] m, input logic sl,
                        input logic sr, input logic [7:0] dd);
        exp_t x;
        @(negedge clk);
        rst_n = 1'b1; en = e; mode = m; sin_l = sl; sin_r = sr; d = dd;
        x.fd = 1'b0;
        if (e) begin
            case (m)
                SHL:  mq = ((mq * 2) + int'(sr)) & MASK;
                SHR:  mq = (mq / 2) + (int'(sl) << (WIDTH - 1));
                LOAD: mq = int'(dd);
                CUP:  mq = (mq + 1) & MASK;
                CDN:  mq = (mq + MASK) & MASK;
                ROTL: mq = ((mq * 2) & MASK) + (mq >> (WIDTH - 1));
                ROTR: mq = (mq / 2) + ((mq % 2) << (WIDTH - 1));
                default: ;
            endcase
            if (m == LOAD) mn = 0;
            if (m == SHL || m == SHR || m == ROTL || m == ROTR) begin
                mn++;
                if (mn == WIDTH) begin
                    mn   = 0;
                    x.fd = 1'b1;
                end
            end
        end
        x.q  = mq[7:0];
        x.tc = tc_of(m, mq);
        sbq.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle asynchronous reset; released by the next step.
    task automatic do_reset();
        exp_t x;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        en    = 1'b0;
        #1;
        chk("rst_async_q", q, RV);
        chk("rst_async_fd", frame_done, 0);
        mq   = int'(RV);
        mn   = 0;
        x.q  = RV;
        x.fd = 1'b0;
        x.tc = tc_of(mode, mq);
        sbq.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Monitor: every clock the DUT presents a new state; compare it with
    // the oldest pending expectation.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("sb_q", q, e.q);
            chk("sb_frame_done", frame_done, e.fd);
            chk("sb_tc", tc, e.tc);
            chk("sb_sout_l", sout_l, e.q[7]);
            chk("sb_sout_r", sout_r, e.q[0]);
        end
    end

    initial begin
        int fd_cnt;
        rst_n = 1'b1; en = 1'b0; mode = HOLD; sin_l = 1'b0; sin_r = 1'b0; d = '0;
        #3;
        rst_n = 1'b0;
        #1;
        chk("init_rst_q", q, RV);
        chk("init_rst_fd", frame_done, 0);
        chk("init_rst_tc", tc, 0);
        mq = int'(RV);
        mn = 0;
        repeat (2) @(posedge clk);

        // Reset/load
        step(1, LOAD, 0, 0, 8'h3C);
        chk("load_3c", q, 8'h3C);
        do_reset();
        chk("rst_mid_q", q, RV);

        // SHL framing
        step(1, LOAD, 0, 0, 8'h00);
        for (int i = 0; i < 8; i++) begin
            step(1, SHL, 0, 1, 8'h00);
            chk("shl_frame_fd", frame_done, (i == 7));
        end
        chk("shl_frame_q", q, 8'hFF);
        step(1, HOLD, 0, 0, 8'h00);
        chk("shl_frame_fd_after", frame_done, 0);

        // Hold within a frame
        step(1, LOAD, 0, 0, 8'h5A);
        fd_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, SHL, 0, 0, 8'h00);
            fd_cnt += int'(frame_done);
        end
        for (int i = 0; i < 3; i++) begin
            step(0, SHL, 0, 1, 8'hFF);
            fd_cnt += int'(frame_done);
            chk("hold_q", q, 8'h40);
        end
        for (int i = 0; i < 3; i++) begin
            step(1, SHR, 1, 0, 8'h00);
            fd_cnt += int'(frame_done);
        end
        chk("hold_frame_fd_last", frame_done, 1);
        chk("hold_frame_fd_count", fd_cnt, 1);

        // Counting and terminal count
        step(1, LOAD, 0, 0, 8'hFE);
        chk("cnt_q_fe", q, 8'hFE);
        step(0, CUP, 0, 0, 8'h00);
        chk("tc_at_fe", tc, 0);
        step(1, CUP, 0, 0, 8'h00);
        chk("cnt_q_ff", q, 8'hFF);
        chk("tc_at_ff", tc, 1);
        step(1, CUP, 0, 0, 8'h00);
        chk("cnt_wrap_q", q, 8'h00);
        chk("cnt_wrap_tc", tc, 0);
        step(0, CDN, 0, 0, 8'h00);
        chk("tc_dn_at_00", tc, 1);
        step(1, CDN, 0, 0, 8'h00);
        chk("cnt_dn_wrap_q", q, 8'hFF);

        // Rotation
        step(1, LOAD, 0, 0, 8'h81);
        step(1, ROTL, 0, 0, 8'h00);
        chk("rotl_q", q, 8'h03);
        step(1, ROTR, 0, 0, 8'h00);
        step(1, ROTR, 0, 0, 8'h00);
        chk("rotr_q", q, 8'hC0);
        chk("rotr_sout_l", sout_l, 1);
        chk("rotr_sout_r", sout_r, 0);

        // Mid-frame abort by LOAD, then by reset pulse
        for (int pass = 0; pass < 2; pass++) begin
            step(1, LOAD, 0, 0, 8'h11);
            for (int i = 0; i < 4; i++) step(1, ROTR, 0, 0, 8'h00);
            if (pass == 0) step(1, LOAD, 0, 0, 8'h00);
            else           do_reset();
            fd_cnt = 0;
            for (int i = 0; i < 7; i++) begin
                step(1, SHL, 0, 1, 8'h00);
                fd_cnt += int'(frame_done);
            end
            chk("abort_no_fd", fd_cnt, 0);
            step(1, SHL, 0, 1, 8'h00);
            chk("abort_fd_8th", frame_done, 1);
        end

        // Randomized traffic against the reference model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 5) != 0), 3'($urandom_range(0, 7)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     8'($urandom_range(0, 255)));
            end
        end

        repeat (2) @(posedge clk);
        #2;
        chk("sb_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
